// File: rtl/lcd_ctrl_param_pkg.sv
// Shared controller state type and command codes for lcd_ctrl_param
// and its window ALU.
package lcd_ctrl_param_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE
  } state_t;

  localparam logic [3:0] CMD_WRITE  = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_AVG    = 4'd5;
  localparam logic [3:0] CMD_MIRX   = 4'd6;
  localparam logic [3:0] CMD_MIRY   = 4'd7;
  localparam logic [3:0] CMD_MAX    = 4'd8;
  localparam logic [3:0] CMD_MIN    = 4'd9;
  localparam logic [3:0] CMD_ROTCCW = 4'd10;
  localparam logic [3:0] CMD_ROTCW  = 4'd11;
  localparam logic [3:0] CMD_CENTRE = 4'd12;

endpackage

// File: rtl/lcd_ctrl_param_win_alu.sv
// Combinational 2x2 window operator: produces the new window pixels and a
// write enable for the pixel-modifying commands.
module lcd_win_alu
  import lcd_ctrl_param_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] tl,
  input  logic [DATA_W-1:0] tr,
  input  logic [DATA_W-1:0] bl,
  input  logic [DATA_W-1:0] br,
  output logic [DATA_W-1:0] new_tl,
  output logic [DATA_W-1:0] new_tr,
  output logic [DATA_W-1:0] new_bl,
  output logic [DATA_W-1:0] new_br,
  output logic              wr_en
);

  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] avg;
  logic [DATA_W-1:0] mx_t, mx_b, mx;
  logic [DATA_W-1:0] mn_t, mn_b, mn;

  always_comb begin
    sum  = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
    avg  = DATA_W'(sum >> 2);
    mx_t = (tl > tr) ? tl : tr;
    mx_b = (bl > br) ? bl : br;
    mx   = (mx_t > mx_b) ? mx_t : mx_b;
    mn_t = (tl < tr) ? tl : tr;
    mn_b = (bl < br) ? bl : br;
    mn   = (mn_t < mn_b) ? mn_t : mn_b;
  end

  always_comb begin
    new_tl = tl;
    new_tr = tr;
    new_bl = bl;
    new_br = br;
    wr_en  = 1'b1;
    case (cmd)
      CMD_AVG: begin
        new_tl = avg; new_tr = avg; new_bl = avg; new_br = avg;
      end
      CMD_MIRX: begin
        new_tl = bl; new_bl = tl; new_tr = br; new_br = tr;
      end
      CMD_MIRY: begin
        new_tl = tr; new_tr = tl; new_bl = br; new_br = bl;
      end
      CMD_MAX: begin
        new_tl = mx; new_tr = mx; new_bl = mx; new_br = mx;
      end
      CMD_MIN: begin
        new_tl = mn; new_tr = mn; new_bl = mn; new_br = mn;
      end
      CMD_ROTCCW: begin
        new_tl = tr; new_tr = br; new_br = bl; new_bl = tl;
      end
      CMD_ROTCW: begin
        new_tl = bl; new_bl = br; new_br = tr; new_tr = tl;
      end
      default: wr_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised image-buffer controller: loads an image from IROM, applies
// window commands at a movable 2x2 point and streams the buffer to IRB.
module lcd_ctrl_param
  import lcd_ctrl_param_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 8,
  parameter  int IMG_H  = 8,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_EN,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRB_RW,
  output logic [ADDR_W-1:0] IRB_A,
  output logic [DATA_W-1:0] IRB_D,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [XW-1:0]   X_CTR  = XW'(IMG_W / 2);
  localparam logic [YW-1:0]   Y_CTR  = YW'(IMG_H / 2);
  localparam logic [XW-1:0]   X_MIN  = XW'(1);
  localparam logic [YW-1:0]   Y_MIN  = YW'(1);
  localparam logic [XW-1:0]   X_MAX  = '1;
  localparam logic [YW-1:0]   Y_MAX  = '1;
  localparam logic [ADDR_W:0] CNT_N  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0] LD_END = (ADDR_W + 1)'(N + 1);
  localparam logic [ADDR_W:0] LD_ST  = (ADDR_W + 1)'(2);

  state_t            state;
  logic [DATA_W-1:0] pix [N];
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [3:0]        cmd_r;
  logic [ADDR_W:0]   ld_cnt;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] ld_prev;

  logic [ADDR_W-1:0] a_tl, a_tr, a_bl, a_br;
  logic [DATA_W-1:0] p_tl, p_tr, p_bl, p_br;
  logic [DATA_W-1:0] n_tl, n_tr, n_bl, n_br;
  logic              alu_wr;

  // Power-of-2 width makes row*IMG_W+col a plain {row,col} concatenation.
  always_comb begin
    a_tl    = {y - YW'(1), x - XW'(1)};
    a_tr    = {y - YW'(1), x};
    a_bl    = {y, x - XW'(1)};
    a_br    = {y, x};
    p_tl    = pix[a_tl];
    p_tr    = pix[a_tr];
    p_bl    = pix[a_bl];
    p_br    = pix[a_br];
    ld_prev = ld_cnt[ADDR_W-1:0] - ADDR_W'(2);
  end

  lcd_win_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd    (cmd_r),
    .tl     (p_tl),
    .tr     (p_tr),
    .bl     (p_bl),
    .br     (p_br),
    .new_tl (n_tl),
    .new_tr (n_tr),
    .new_bl (n_bl),
    .new_br (n_br),
    .wr_en  (alu_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_LOAD;
      x       <= X_CTR;
      y       <= Y_CTR;
      cmd_r   <= '0;
      ld_cnt  <= '0;
      wr_cnt  <= '0;
      IROM_EN <= 1'b1;
      IROM_A  <= '0;
      IRB_RW  <= 1'b1;
      IRB_A   <= '0;
      IRB_D   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      case (state)
        // Address k goes out in step k; its data is stored two steps later.
        S_LOAD: begin
          if (ld_cnt < CNT_N) begin
            IROM_EN <= 1'b0;
            IROM_A  <= ld_cnt[ADDR_W-1:0];
          end
          if (ld_cnt >= LD_ST) pix[ld_prev] <= IROM_Q;
          if (ld_cnt == LD_END) begin
            IROM_EN <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
          ld_cnt <= ld_cnt + 1'b1;
        end
        S_IDLE: begin
          if (cmd_valid && !busy) begin
            cmd_r <= cmd;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cmd_r == CMD_WRITE) begin
            IRB_RW <= 1'b0;
            IRB_A  <= '0;
            IRB_D  <= pix[0];
            wr_cnt <= (ADDR_W + 1)'(1);
            state  <= S_WRITE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
            case (cmd_r)
              CMD_UP:     if (y != Y_MIN) y <= y - YW'(1);
              CMD_DOWN:   if (y != Y_MAX) y <= y + YW'(1);
              CMD_LEFT:   if (x != X_MIN) x <= x - XW'(1);
              CMD_RIGHT:  if (x != X_MAX) x <= x + XW'(1);
              CMD_CENTRE: begin
                x <= X_CTR;
                y <= Y_CTR;
              end
              default: ;
            endcase
            if (alu_wr) begin
              pix[a_tl] <= n_tl;
              pix[a_tr] <= n_tr;
              pix[a_bl] <= n_bl;
              pix[a_br] <= n_br;
            end
          end
        end
        S_WRITE: begin
          if (wr_cnt == CNT_N) begin
            IRB_RW <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            IRB_A  <= wr_cnt[ADDR_W-1:0];
            IRB_D  <= pix[wr_cnt[ADDR_W-1:0]];
            wr_cnt <= wr_cnt + 1'b1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
